// File: rtl/button_events.sv
// Button event decoder: turns a debounced button level into press, release,
// short-press, long-press and auto-repeat pulses plus a held level.
module button_events #(
    parameter int unsigned LONG_TIME   = 8,
    parameter int unsigned REPEAT_TIME = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic debounced_button,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int unsigned MAX_TIME = (LONG_TIME > REPEAT_TIME) ? LONG_TIME : REPEAT_TIME;
    localparam int unsigned CNT_W    = (MAX_TIME > 2) ? $clog2(MAX_TIME) : 1;
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESSED = 2'b01,
        HELD    = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic press_next;
    logic release_next;
    logic short_next;
    logic long_next;
    logic repeat_next;
    logic held_next;

    // State, counter and output registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            short_pulse   <= short_next;
            long_pulse    <= long_next;
            repeat_pulse  <= repeat_next;
            held          <= held_next;
        end
    end

    // Next state and counter; release always wins over the threshold compare
    always_comb begin
        state_next = IDLE;
        cnt_next   = '0;
        case (state)
            IDLE: begin
                if (debounced_button) begin
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (!debounced_button) begin
                    state_next = IDLE;
                end else if (cnt == LONG_LAST) begin
                    state_next = HELD;
                end else begin
                    state_next = PRESSED;
                    cnt_next   = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!debounced_button) begin
                    state_next = IDLE;
                end else if (cnt == REPEAT_LAST) begin
                    state_next = HELD;
                end else begin
                    state_next = HELD;
                    cnt_next   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Next values of the registered outputs; pulses default low every cycle
    always_comb begin
        press_next   = 1'b0;
        release_next = 1'b0;
        short_next   = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;
        held_next    = 1'b0;
        case (state)
            IDLE: begin
                press_next = debounced_button;
            end
            PRESSED: begin
                if (!debounced_button) begin
                    release_next = 1'b1;
                    short_next   = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    long_next = 1'b1;
                    held_next = 1'b1;
                end
            end
            HELD: begin
                if (!debounced_button) begin
                    release_next = 1'b1;
                end else begin
                    held_next   = 1'b1;
                    repeat_next = (cnt == REPEAT_LAST);
                end
            end
            default: begin
                held_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: per-cycle vectors with expected outputs go through
// a scoreboard queue and are compared one step after each rising edge.
module tb_button_events;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic debounced_button = 1'b0;
    logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;

    // expected bit order: {press, release, short, long, repeat, held}
    localparam logic [5:0] P  = 6'b100000;
    localparam logic [5:0] RS = 6'b011000;
    localparam logic [5:0] R  = 6'b010000;
    localparam logic [5:0] L  = 6'b000100;
    localparam logic [5:0] RP = 6'b000010;
    localparam logic [5:0] H  = 6'b000001;

    typedef struct {
        logic       rst;
        logic       btn;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        logic [5:0] exp;
        int         idx;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    logic [4:0] prev_pulses = '0;

    button_events #(.LONG_TIME(8), .REPEAT_TIME(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .debounced_button (debounced_button),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .short_pulse      (short_pulse),
        .long_pulse       (long_pulse),
        .repeat_pulse     (repeat_pulse),
        .held             (held)
    );

    always #5 clk = ~clk;

    // Monitor: compare against the scoreboard and check pulse invariants
    always @(posedge clk) begin
        logic [5:0] got;
        logic [4:0] pulses;
        sb_t        e;
        #1;
        got    = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held};
        pulses = got[5:1];
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL outputs step %0d: got %b expected %b", e.idx, got, e.exp);
            end
            checks++;
            if (!($countones(pulses) <= 1 || pulses == 5'b01100)) begin
                errors++;
                $display("FAIL exclusive step %0d: pulses %b", e.idx, pulses);
            end
            checks++;
            if ((pulses & prev_pulses) != 5'b0) begin
                errors++;
                $display("FAIL width step %0d: pulses %b previous %b", e.idx, pulses, prev_pulses);
            end
        end
        prev_pulses = pulses;
    end

    // Drive one cycle of inputs and queue what must appear after the edge
    task automatic step(input logic r, input logic b, input logic [5:0] e);
        sb_t s;
        @(negedge clk);
        rst = r;
        debounced_button = b;
        s.exp = e;
        s.idx = step_no;
        sb.push_back(s);
        step_no++;
    endtask

    task automatic add(input logic r, input logic b);
        vec_t v;
        v.rst = r;
        v.btn = b;
        v.exp = '0;
        tbl.push_back(v);
    endtask

    // Two idle cycles, hi cycles high, three low; base = index of first high
    task automatic add_press(input int hi, output int base);
        add(1'b0, 1'b0);
        add(1'b0, 1'b0);
        base = tbl.size();
        for (int i = 0; i < hi; i++) add(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0);
    endtask

    // Output labelled t+n in the timing description sits at vector t+n-1
    task automatic mark(input int idx, input logic [5:0] m);
        tbl[idx].exp = tbl[idx].exp | m;
    endtask

    initial begin
        int b;

        // reset dominates a high button, then a quiet cycle
        add(1'b1, 1'b1);
        add(1'b1, 1'b0);

        // short press, 3 cycles
        add_press(3, b);
        mark(b, P);
        mark(b + 3, RS);

        // long hold, 20 cycles: long, held, two repeats, plain release
        add_press(20, b);
        mark(b, P);
        mark(b + 8, L);
        for (int i = 8; i < 20; i++) mark(b + i, H);
        mark(b + 12, RP);
        mark(b + 16, RP);
        mark(b + 20, R);

        // release exactly on the long threshold: short, never long
        add_press(8, b);
        mark(b, P);
        mark(b + 8, RS);

        // release exactly on the repeat threshold: release only, never repeat
        add_press(12, b);
        mark(b, P);
        mark(b + 8, L);
        for (int i = 8; i < 12; i++) mark(b + i, H);
        mark(b + 12, R);

        // held through one repeat, released one cycle later
        add_press(13, b);
        mark(b, P);
        mark(b + 8, L);
        for (int i = 8; i < 13; i++) mark(b + i, H);
        mark(b + 12, RP);
        mark(b + 13, R);

        // single-cycle press
        add_press(1, b);
        mark(b, P);
        mark(b + 1, RS);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].btn, tbl[i].exp);
        end

        // reset mid-hold while the button stays high: clean restart, no release
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, P);
        for (int i = 1; i < 8; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, L | H);
        step(1'b0, 1'b1, H);
        step(1'b0, 1'b1, H);
        step(1'b1, 1'b1, '0);
        step(1'b0, 1'b1, P);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, RS);
        step(1'b0, 1'b0, '0);

        // reset in PRESSED together with a release: no short or release pulse
        step(1'b0, 1'b1, P);
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, P);
        step(1'b0, 1'b0, RS);
        step(1'b0, 1'b0, '0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
